// File: rtl/gate_truth_table_checker.sv
// Purpose : sequences a small combinational gate through every input vector and checks it against a truth table.
// Latency : accepted start to done pulse = 2^N_INPUTS*(SETTLE_CYCLES+1)+1 cycles (9 with defaults).
// Backpressure: none; start is honoured only in IDLE and ignored while busy or in DONE.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           single-cycle run request
//   vec             vector driven to the gate under test (bit 0 = A, bit 1 = B)
//   gate_y          gate output, sampled only in CHECK
//   busy, done      run in progress / one-cycle end-of-run pulse
//   pass            last completed run had no mismatches
//   fail_count      mismatches in current/last run
//   first_fail_idx  vector index of the first mismatch (0 if none)
//
// Optional feature: define CHECK_STOP_ON_FAIL_EN to end the run at the first mismatch.

module gate_truth_table_checker #(
   parameter int                        N_INPUTS      = 2,
   parameter logic [(2**N_INPUTS)-1:0]  EXPECTED      = 4'b1000,
   parameter int                        SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [N_INPUTS-1:0]   vec,
   input  logic                  gate_y,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_INPUTS:0]     fail_count,
   output logic [N_INPUTS-1:0]   first_fail_idx
);

   localparam int             CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [N_INPUTS-1:0]  vec_n;
   logic [N_INPUTS:0]    fail_count_n;
   logic [N_INPUTS-1:0]  first_fail_idx_n;
   logic                 pass_n;
   logic                 mismatch;
   logic                 stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         vec            <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
         pass           <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         vec            <= vec_n;
         fail_count     <= fail_count_n;
         first_fail_idx <= first_fail_idx_n;
         pass           <= pass_n;
      end
   end

   always_comb begin
      state_n          = state;
      cnt_n            = cnt;
      vec_n            = vec;
      fail_count_n     = fail_count;
      first_fail_idx_n = first_fail_idx;
      pass_n           = pass;
      mismatch         = 1'b0;
      stop             = 1'b0;

      case (state)
         S_IDLE: begin
            vec_n = '0;
            if (start) begin
               state_n          = S_WAIT;
               cnt_n            = '0;
               fail_count_n     = '0;
               first_fail_idx_n = '0;
               pass_n           = 1'b0;
            end
         end

         S_WAIT: begin
            // Counter holds at its terminal value for the single cycle that
            // hands over to CHECK, giving exactly SETTLE_CYCLES cycles here.
            if (cnt == CNT_LAST) begin
               state_n = S_CHECK;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end

         S_CHECK: begin
            mismatch = (gate_y != EXPECTED[vec]);
            if (mismatch) begin
               fail_count_n = fail_count + 1'b1;
               if (fail_count == '0) begin
                  first_fail_idx_n = vec;
               end
            end
            stop = &vec;
`ifdef CHECK_STOP_ON_FAIL_EN
            stop = stop | mismatch;
`endif
            if (stop) begin
               state_n = S_DONE;
            end else begin
               vec_n   = vec + 1'b1;
               cnt_n   = '0;
               state_n = S_WAIT;
            end
         end

         S_DONE: begin
            pass_n  = (fail_count == '0);
            vec_n   = '0;
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign busy = (state == S_WAIT) || (state == S_CHECK);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: default AND instance plus an
// SETTLE_CYCLES=3 OR instance; expectations are hand-computed cycle numbers.

module tb_gate_truth_table_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] vec;
   logic       gate_y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] fail_count;
   logic [1:0] first_fail_idx;

   logic       start2;
   logic [1:0] vec2;
   logic       gate_y2;
   logic       busy2;
   logic       done2;
   logic       pass2;
   logic [2:0] fail_count2;
   logic [1:0] first_fail_idx2;

   int mode;      // 0 = AND, 1 = stuck-at-0, 2 = NAND
   int n_checks;
   int n_fail;

   gate_truth_table_checker dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .vec            (vec),
      .gate_y         (gate_y),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx)
   );

   gate_truth_table_checker #(
      .N_INPUTS      (2),
      .EXPECTED      (4'b1110),
      .SETTLE_CYCLES (3)
   ) dut_or (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start2),
      .vec            (vec2),
      .gate_y         (gate_y2),
      .busy           (busy2),
      .done           (done2),
      .pass           (pass2),
      .fail_count     (fail_count2),
      .first_fail_idx (first_fail_idx2)
   );

   assign gate_y  = (mode == 0) ? (vec[0] & vec[1]) :
                    (mode == 1) ? 1'b0 : ~(vec[0] & vec[1]);
   assign gate_y2 = vec2[0] | vec2[1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 1 of the run (start sampled at end of cycle 0).
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns the cycle index at which done is seen, or -1 on timeout.
   task automatic wait_done(input bit second, input int from_cyc, output int cyc);
      cyc = from_cyc;
      while (((second ? done2 : done) !== 1'b1) && cyc < 40) begin
         tick();
         cyc++;
      end
      if ((second ? done2 : done) !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if ({busy, done, pass, vec, fail_count, first_fail_idx} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b vec=%0d fc=%0d ffi=%0d, want all 0",
                  busy, done, pass, vec, fail_count, first_fail_idx);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if ({busy2, done2, pass2, vec2, fail_count2, first_fail_idx2} !== 10'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got busy=%b busy2=%b vec2=%0d fc2=%0d, want 0", busy, busy2, vec2, fail_count2);
      end
   endtask

   task automatic test_and_pass();
      mode = 0;
      pulse_start();
      for (int c = 1; c <= 8; c++) begin
         n_checks++;
         if (vec !== 2'((c - 1) / 2) || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL and_seq cycle %0d: got vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
                     c, vec, busy, done, (c - 1) / 2);
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || fail_count !== 3'd0 || first_fail_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL and_done_c9: got done=%b busy=%b fc=%0d ffi=%0d, want 1 0 0 0",
                  done, busy, fail_count, first_fail_idx);
      end
      tick();
      n_checks++;
      if (pass !== 1'b1 || done !== 1'b0 || vec !== 2'd0) begin
         n_fail++;
         $display("FAIL and_pass: got pass=%b done=%b vec=%0d, want 1 0 0", pass, done, vec);
      end
   endtask

   task automatic test_stuck0();
      int cyc;
      mode = 1;
      pulse_start();
      wait_done(1'b0, 1, cyc);
      n_checks++;
      if (cyc !== 9 || fail_count !== 3'd1 || first_fail_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL stuck0: got done_cyc=%0d fc=%0d ffi=%0d, want 9 1 3", cyc, fail_count, first_fail_idx);
      end
      tick();
      n_checks++;
      if (pass !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck0_pass: got %b, want 0", pass);
      end
   endtask

   task automatic test_nand();
      int cyc;
      int exp_cyc;
      logic [2:0] exp_fc;
`ifdef CHECK_STOP_ON_FAIL_EN
      exp_cyc = 3;
      exp_fc  = 3'd1;
`else
      exp_cyc = 9;
      exp_fc  = 3'd4;
`endif
      mode = 2;
      pulse_start();
      wait_done(1'b0, 1, cyc);
      n_checks++;
      if (cyc !== exp_cyc || fail_count !== exp_fc || first_fail_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL nand: got done_cyc=%0d fc=%0d ffi=%0d, want %0d %0d 0",
                  cyc, fail_count, first_fail_idx, exp_cyc, exp_fc);
      end
      tick();
      n_checks++;
      if (pass !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL nand_pass: got pass=%b busy=%b, want 0 0", pass, busy);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      mode = 0;
      pulse_start();      // cycle 1
      tick();             // cycle 2
      start = 1'b1;
      tick();             // cycle 3
      start = 1'b0;
      tick();             // cycle 4
      tick();             // cycle 5
      start = 1'b1;
      tick();             // cycle 6
      start = 1'b0;
      n_checks++;
      if (vec !== 2'd2 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reprobe_c6: got vec=%0d busy=%b, want 2 1", vec, busy);
      end
      wait_done(1'b0, 6, cyc);
      n_checks++;
      if (cyc !== 9 || fail_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reprobe_done: got done_cyc=%0d fc=%0d, want 9 0", cyc, fail_count);
      end
      tick();             // IDLE, previous run passed
      n_checks++;
      if (pass !== 1'b1) begin
         n_fail++;
         $display("FAIL reprobe_pass: got %b, want 1", pass);
      end
      pulse_start();
      n_checks++;
      if (pass !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_clears_pass: got pass=%b busy=%b, want 0 1", pass, busy);
      end
      wait_done(1'b0, 1, cyc);
      tick();
      n_checks++;
      if (cyc !== 9 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_run: got done_cyc=%0d pass=%b, want 9 1", cyc, pass);
      end
   endtask

   task automatic test_reset_abort();
      int cyc;
      int seen;
      mode = 2;
      pulse_start();      // cycle 1
      tick();
      tick();
      tick();             // cycle 4
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || vec !== 2'd0 || fail_count !== 3'd0 || first_fail_idx !== 2'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: got busy=%b vec=%0d fc=%0d ffi=%0d done=%b, want all 0",
                  busy, vec, fail_count, first_fail_idx, done);
      end
      seen = 0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
      end
      mode = 0;
      pulse_start();
      wait_done(1'b0, 1, cyc);
      tick();
      n_checks++;
      if (cyc !== 9 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rerun: got done_cyc=%0d pass=%b, want 9 1", cyc, pass);
      end
   endtask

   task automatic test_settle3_or();
      int cyc;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         n_checks++;
         if (vec2 !== 2'((c - 1) / 4) || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL or_seq cycle %0d: got vec=%0d busy=%b, want vec=%0d busy=1",
                     c, vec2, busy2, (c - 1) / 4);
         end
         tick();
      end
      wait_done(1'b1, 17, cyc);
      n_checks++;
      if (cyc !== 17 || fail_count2 !== 3'd0 || busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL or_done: got done_cyc=%0d fc=%0d busy=%b, want 17 0 0", cyc, fail_count2, busy2);
      end
      tick();
      n_checks++;
      if (pass2 !== 1'b1) begin
         n_fail++;
         $display("FAIL or_pass: got %b, want 1", pass2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mode     = 0;
      start    = 1'b0;
      start2   = 1'b0;
      rst_n    = 1'b0;
      test_reset();
      test_and_pass();
      test_stuck0();
      test_nand();
      test_start_ignored();
      test_reset_abort();
      test_settle3_or();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Self-test controller that sequences a combinational gate under test (e.g. a 2-input AND) through every input combination. It waits a programmable settle time per vector, samples the gate output and compares it against a parameterised expected truth table. It reports pass/fail, the mismatch count and the first failing vector. It sits beside any small gate block and replaces hand-written stimulus sequencing.

Parameters:
N_INPUTS, 2, number of gate inputs; vectors run 0 .. 2^N_INPUTS-1 (range 1..4).
EXPECTED, 4'b1000, expected output per vector; bit i is expected Y for input vector i; width 2^N_INPUTS. Default is AND.
SETTLE_CYCLES, 1, wait cycles after a vector is driven, before sampling (>=1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a run; honoured only in IDLE.
vec  output  N_INPUTS  input vector driven to the gate under test; bit 0 = A, bit 1 = B.
gate_y  input  1  output of the gate under test.
busy  output  1  high from the cycle after start is accepted until the DONE cycle (exclusive).
done  output  1  one-cycle pulse at end of run.
pass  output  1  1 when the last completed run had zero mismatches; held until the next start is accepted.
fail_count  output  N_INPUTS+1  mismatches in current/last run.
first_fail_idx  output  N_INPUTS  vector index of the first mismatch; 0 if none.

Behaviour:
- Reset (async assert, sync release): state=IDLE, vec=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0; internal settle counter=0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - vec held at 0.
  - start=1 -> WAIT next cycle; clear fail_count, first_fail_idx and pass; settle counter=0; busy=1.
- WAIT:
  - Counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1 -> CHECK.
  - Exactly SETTLE_CYCLES cycles in WAIT per vector.
- CHECK (one cycle):
  - Compare gate_y to EXPECTED[vec].
  - On mismatch: fail_count += 1. If it was 0 before this increment, first_fail_idx <= vec.
  - If vec == 2^N_INPUTS-1 -> DONE.
  - Otherwise vec <= vec+1, counter=0, -> WAIT.
- DONE (one cycle):
  - done=1, busy=0, pass <= (fail_count==0).
  - vec <= 0; -> IDLE.
- Latency: accepted start to done pulse = 2^N_INPUTS*(SETTLE_CYCLES+1)+1 cycles. Defaults: 9 cycles (start in cycle 0, done in cycle 9).
- vec changes only on the CHECK->WAIT transition and is stable through each WAIT/CHECK window.
- start while busy or in DONE: ignored, no effect on the run.
- fail_count cannot overflow: max 2^N_INPUTS fits in N_INPUTS+1 bits.
- Reset mid-run aborts immediately: all outputs return to reset values and no done pulse is issued.
- gate_y is sampled only in CHECK; its value elsewhere is don't-care.

Optional Feature:
Macro CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. Result: fail_count=1, first_fail_idx = failing vector, pass=0, and the run is shortened.
- Undefined: all vectors are always run and every mismatch is counted.

Test Plan:
- Defaults, gate_y = A&B of vec, pulse start -> vec steps 0,1,2,3 every 2 cycles; done 9 cycles after start; pass=1, fail_count=0, first_fail_idx=0.
- gate_y tied 0 (stuck-at-0) -> done at cycle 9; pass=0, fail_count=1, first_fail_idx=3.
- gate_y = ~(A&B) (NAND) -> fail_count=4, first_fail_idx=0, pass=0. With CHECK_STOP_ON_FAIL_EN: done 3 cycles after start, fail_count=1, first_fail_idx=0.
- start re-pulsed at cycles 2 and 5 of an AND run -> ignored; done still at cycle 9, pass=1. Then start in IDLE -> new run, and pass drops to 0 the cycle after start.
- rst_n low at cycle 4 of a run -> busy=0, vec=0, fail_count=0 asynchronously; no done pulse; a subsequent start runs a full 9-cycle sequence.
- SETTLE_CYCLES=3, gate_y = A|B with EXPECTED=4'b1110 -> vec holds 4 cycles per vector; done 17 cycles after start; pass=1.
